// File: rtl/axi_stream_extract_header.sv
// Splits a per-packet header off an AXI-Stream onto m00 and realigns the payload onto m01.
// Build option AXIS_EXTRACT_HDR_SKID_EN: 2-entry payload skid, registered s_axis_tready.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_len_tvalid,
  output logic                    s_len_tready,
  input  logic [LEN_WD-1:0]       s_len_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WD-1:0]      s_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m00_axis_tvalid,
  input  logic                    m00_axis_tready,
  output logic [DATA_WD-1:0]      m00_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m00_axis_tkeep,
  output logic                    m01_axis_tvalid,
  input  logic                    m01_axis_tready,
  output logic [DATA_WD-1:0]      m01_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m01_axis_tkeep,
  output logic                    m01_axis_tlast,
  output logic                    runt_o
);

  localparam int SH_WD = $clog2(DATA_WD + 1);
  localparam logic [LEN_WD-1:0] LEN_MAX = LEN_WD'(DATA_BYTE_WD);
  localparam logic [DATA_BYTE_WD-1:0] ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_FLUSH
  } state_t;

  function automatic logic [DATA_WD-1:0] lane_mask(
    input logic [DATA_BYTE_WD-1:0] k
  );
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [LEN_WD-1:0] count_ones(
    input logic [DATA_BYTE_WD-1:0] k
  );
    logic [LEN_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + LEN_WD'(k[i]);
    return c;
  endfunction

  state_t                  state_q, state_d;
  logic [LEN_WD-1:0]       len_q, len_d;
  logic                    len_rdy_q, len_rdy_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [DATA_WD-1:0]      fl_data_q, fl_data_d;
  logic [DATA_BYTE_WD-1:0] fl_keep_q, fl_keep_d;
  logic                    m00_v_q, m00_v_d;
  logic [DATA_WD-1:0]      m00_data_q, m00_data_d;
  logic [DATA_BYTE_WD-1:0] m00_keep_q, m00_keep_d;
  logic                    runt_q, runt_d;
  logic                    m01_v_q, m01_v_d;
  logic [DATA_WD-1:0]      m01_data_q, m01_data_d;
  logic [DATA_BYTE_WD-1:0] m01_keep_q, m01_keep_d;
  logic                    m01_last_q, m01_last_d;

  logic                    pl_push;
  logic [DATA_WD-1:0]      pl_data;
  logic [DATA_BYTE_WD-1:0] pl_keep;
  logic                    pl_last;
  logic                    pop, space, in_hs;

  logic [LEN_WD-1:0]       len_in, in_k;
  logic [DATA_WD-1:0]      in_beat, head_bits, tail;
  logic [SH_WD-1:0]        sh_hdr, sh_len, sh_k;
  logic [DATA_BYTE_WD-1:0] hdr_keep, runt_keep;
  logic [DATA_BYTE_WD-1:0] body_keep, tail_keep;

  assign len_in = (s_len_tdata == '0 || s_len_tdata > LEN_MAX)
                  ? LEN_MAX : s_len_tdata;
  assign in_beat = s_axis_tdata & lane_mask(s_axis_tkeep);
  assign in_k = count_ones(s_axis_tkeep);

  assign sh_hdr = SH_WD'(LEN_MAX - len_q) << 3;
  assign sh_len = SH_WD'(len_q) << 3;
  assign sh_k   = SH_WD'(LEN_MAX - in_k) << 3;

  // head_bits: first L bytes right-aligned; tail: bytes after L left-aligned
  assign head_bits = in_beat >> sh_hdr;
  assign tail      = in_beat << sh_len;
  assign hdr_keep  = ~(ONES << len_q);
  assign runt_keep = ~(ONES << in_k);
  assign body_keep = (s_axis_tkeep >> (LEN_MAX - len_q)) | (ONES << len_q);
  assign tail_keep = s_axis_tkeep << len_q;

  assign pop = m01_v_q & m01_axis_tready;

`ifdef AXIS_EXTRACT_HDR_SKID_EN
  logic                    sk_v_q, sk_v_d;
  logic [DATA_WD-1:0]      sk_data_q, sk_data_d;
  logic [DATA_BYTE_WD-1:0] sk_keep_q, sk_keep_d;
  logic                    sk_last_q, sk_last_d;
  logic                    axis_rdy_q, axis_rdy_d;

  assign space = ~sk_v_q;
  assign s_axis_tready = axis_rdy_q;
`else
  logic in_en;

  assign in_en = ((state_q == ST_HDR) & ~m00_v_q) | (state_q == ST_BODY);
  assign space = ~m01_v_q | m01_axis_tready;
  assign s_axis_tready = in_en & space;
`endif

  assign in_hs = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    res_d      = res_q;
    fl_data_d  = fl_data_q;
    fl_keep_d  = fl_keep_q;
    m00_v_d    = m00_v_q;
    m00_data_d = m00_data_q;
    m00_keep_d = m00_keep_q;
    runt_d     = 1'b0;
    pl_push    = 1'b0;
    pl_data    = '0;
    pl_keep    = '0;
    pl_last    = 1'b0;
    if (m00_v_q && m00_axis_tready) begin
      m00_v_d    = 1'b0;
      m00_data_d = '0;
      m00_keep_d = '0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (s_len_tvalid && len_rdy_q) begin
          len_d   = len_in;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (in_hs) begin
          m00_v_d = 1'b1;
          res_d   = tail;
          if (s_axis_tlast && in_k <= len_q) begin
            m00_data_d = in_beat >> sh_k;
            m00_keep_d = runt_keep;
            runt_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            m00_data_d = head_bits;
            m00_keep_d = hdr_keep;
            if (s_axis_tlast) begin
              pl_push = 1'b1;
              pl_data = tail;
              pl_keep = tail_keep;
              pl_last = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BODY;
            end
          end
        end
      end
      ST_BODY: begin
        if (in_hs) begin
          pl_push = 1'b1;
          pl_data = res_q | head_bits;
          pl_keep = body_keep;
          res_d   = tail;
          if (s_axis_tlast) begin
            if (in_k <= len_q) begin
              pl_last = 1'b1;
              state_d = ST_IDLE;
            end else begin
              fl_data_d = tail;
              fl_keep_d = tail_keep;
              state_d   = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (space) begin
          pl_push   = 1'b1;
          pl_data   = fl_data_q;
          pl_keep   = fl_keep_q;
          pl_last   = 1'b1;
          fl_data_d = '0;
          fl_keep_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    len_rdy_d = (state_d == ST_IDLE);
  end

`ifdef AXIS_EXTRACT_HDR_SKID_EN
  // pushes land in the output register when free, else in the skid entry
  always_comb begin
    m01_v_d    = m01_v_q;
    m01_data_d = m01_data_q;
    m01_keep_d = m01_keep_q;
    m01_last_d = m01_last_q;
    sk_v_d     = sk_v_q;
    sk_data_d  = sk_data_q;
    sk_keep_d  = sk_keep_q;
    sk_last_d  = sk_last_q;
    if (pop) begin
      m01_v_d    = sk_v_q;
      m01_data_d = sk_data_q;
      m01_keep_d = sk_keep_q;
      m01_last_d = sk_last_q;
      sk_v_d     = 1'b0;
      sk_data_d  = '0;
      sk_keep_d  = '0;
      sk_last_d  = 1'b0;
    end
    if (pl_push) begin
      if (!m01_v_d) begin
        m01_v_d    = 1'b1;
        m01_data_d = pl_data;
        m01_keep_d = pl_keep;
        m01_last_d = pl_last;
      end else begin
        sk_v_d    = 1'b1;
        sk_data_d = pl_data;
        sk_keep_d = pl_keep;
        sk_last_d = pl_last;
      end
    end
    axis_rdy_d = ~sk_v_d & (((state_d == ST_HDR) & ~m00_v_d)
                           | (state_d == ST_BODY));
  end
`else
  always_comb begin
    m01_v_d    = m01_v_q;
    m01_data_d = m01_data_q;
    m01_keep_d = m01_keep_q;
    m01_last_d = m01_last_q;
    if (pl_push) begin
      m01_v_d    = 1'b1;
      m01_data_d = pl_data;
      m01_keep_d = pl_keep;
      m01_last_d = pl_last;
    end else if (pop) begin
      m01_v_d    = 1'b0;
      m01_data_d = '0;
      m01_keep_d = '0;
      m01_last_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_MAX;
      len_rdy_q  <= 1'b0;
      res_q      <= '0;
      fl_data_q  <= '0;
      fl_keep_q  <= '0;
      m00_v_q    <= 1'b0;
      m00_data_q <= '0;
      m00_keep_q <= '0;
      runt_q     <= 1'b0;
      m01_v_q    <= 1'b0;
      m01_data_q <= '0;
      m01_keep_q <= '0;
      m01_last_q <= 1'b0;
`ifdef AXIS_EXTRACT_HDR_SKID_EN
      sk_v_q     <= 1'b0;
      sk_data_q  <= '0;
      sk_keep_q  <= '0;
      sk_last_q  <= 1'b0;
      axis_rdy_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      len_rdy_q  <= len_rdy_d;
      res_q      <= res_d;
      fl_data_q  <= fl_data_d;
      fl_keep_q  <= fl_keep_d;
      m00_v_q    <= m00_v_d;
      m00_data_q <= m00_data_d;
      m00_keep_q <= m00_keep_d;
      runt_q     <= runt_d;
      m01_v_q    <= m01_v_d;
      m01_data_q <= m01_data_d;
      m01_keep_q <= m01_keep_d;
      m01_last_q <= m01_last_d;
`ifdef AXIS_EXTRACT_HDR_SKID_EN
      sk_v_q     <= sk_v_d;
      sk_data_q  <= sk_data_d;
      sk_keep_q  <= sk_keep_d;
      sk_last_q  <= sk_last_d;
      axis_rdy_q <= axis_rdy_d;
`endif
    end
  end

  assign s_len_tready    = len_rdy_q;
  assign m00_axis_tvalid = m00_v_q;
  assign m00_axis_tdata  = m00_data_q;
  assign m00_axis_tkeep  = m00_keep_q;
  assign m01_axis_tvalid = m01_v_q;
  assign m01_axis_tdata  = m01_data_q;
  assign m01_axis_tkeep  = m01_keep_q;
  assign m01_axis_tlast  = m01_last_q;
  assign runt_o          = runt_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed vectors, random
// packets against a byte-level model, throttled readies, mid-packet reset.
module tb_axi_stream_extract_header;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LW = $clog2(BW + 1);
  localparam int LIMIT = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_len_tvalid = 1'b0;
  logic          s_len_tready;
  logic [LW-1:0] s_len_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [BW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m00_axis_tvalid;
  logic          m00_axis_tready = 1'b0;
  logic [DW-1:0] m00_axis_tdata;
  logic [BW-1:0] m00_axis_tkeep;
  logic          m01_axis_tvalid;
  logic          m01_axis_tready = 1'b0;
  logic [DW-1:0] m01_axis_tdata;
  logic [BW-1:0] m01_axis_tkeep;
  logic          m01_axis_tlast;
  logic          runt_o;

  int total = 0;
  int bad = 0;
  int runt_exp = 0;
  int runt_seen = 0;
  bit thr = 1'b0;
  bit ignore = 1'b0;
  bit hung = 1'b0;

  logic [BW+DW-1:0]   exp_m00[$];
  logic [BW+DW:0]     exp_m01[$];

  always #5 clk = ~clk;

  axi_stream_extract_header dut (
    .clk             (clk),
    .rst             (rst),
    .s_len_tvalid    (s_len_tvalid),
    .s_len_tready    (s_len_tready),
    .s_len_tdata     (s_len_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tkeep  (m00_axis_tkeep),
    .m01_axis_tvalid (m01_axis_tvalid),
    .m01_axis_tready (m01_axis_tready),
    .m01_axis_tdata  (m01_axis_tdata),
    .m01_axis_tkeep  (m01_axis_tkeep),
    .m01_axis_tlast  (m01_axis_tlast),
    .runt_o          (runt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (thr) begin
      m00_axis_tready = 1'($urandom_range(0, 1));
      m01_axis_tready = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  // output monitors: every accepted beat must match the expected queue head
  always @(negedge clk) begin
    logic [BW+DW-1:0] e0;
    logic [BW+DW:0]   e1;
    if (!rst && !ignore) begin
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_m00.size() == 0) begin
          check("m00_pending", 64'(exp_m00.size()), 64'd1);
        end else begin
          e0 = exp_m00.pop_front();
          check("m00_beat", 64'({m00_axis_tkeep, m00_axis_tdata}), 64'(e0));
        end
      end
      if (m01_axis_tvalid && m01_axis_tready) begin
        if (exp_m01.size() == 0) begin
          check("m01_pending", 64'(exp_m01.size()), 64'd1);
        end else begin
          e1 = exp_m01.pop_front();
          check("m01_beat", 64'({m01_axis_tlast, m01_axis_tkeep,
                                 m01_axis_tdata}), 64'(e1));
        end
      end
      if (runt_o) runt_seen++;
    end
  end

  task automatic drive_len(input int l);
    int n;
    n = 0;
    s_len_tdata = LW'(l);
    s_len_tvalid = 1'b1;
    while (!s_len_tready && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) hung = 1'b1;
    check("len_wait_ok", 64'(n < LIMIT), 64'd1);
    tick();
    s_len_tvalid = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [BW-1:0] k,
                            input logic last);
    int n;
    n = 0;
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) hung = 1'b1;
    check("beat_wait_ok", 64'(n < LIMIT), 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  // disabled input lanes carry random garbage on purpose
  task automatic send_pkt(input int lraw, input logic [7:0] pk[$]);
    int nb;
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    if (hung) return;
    drive_len(lraw);
    nb = (pk.size() + BW - 1) / BW;
    for (int b = 0; b < nb; b++) begin
      d = DW'($urandom);
      k = '0;
      for (int i = 0; i < BW; i++) begin
        if (b * BW + i < pk.size()) begin
          d[DW-1-8*i -: 8] = pk[b*BW+i];
          k[BW-1-i] = 1'b1;
        end
      end
      drive_beat(d, k, b == nb - 1);
      if (thr && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic model(input int lraw, input logic [7:0] pk[$]);
    int le, h, np;
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    le = (lraw == 0 || lraw > BW) ? BW : lraw;
    h = (pk.size() < le) ? pk.size() : le;
    d = '0;
    for (int j = 0; j < h; j++) d[8*(h-1-j) +: 8] = pk[j];
    exp_m00.push_back({BW'((1 << h) - 1), d});
    if (pk.size() <= le) begin
      runt_exp++;
    end else begin
      np = pk.size() - le;
      for (int b = 0; b * BW < np; b++) begin
        d = '0;
        k = '0;
        for (int i = 0; i < BW; i++) begin
          if (b * BW + i < np) begin
            d[DW-1-8*i -: 8] = pk[le+b*BW+i];
            k[BW-1-i] = 1'b1;
          end
        end
        exp_m01.push_back({(b + 1) * BW >= np, k, d});
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_m00.size() != 0 || exp_m01.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check("drain_m00_left", 64'(exp_m00.size()), 64'd0);
    check("drain_m01_left", 64'(exp_m01.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] pk[$];
    int lr;
    int nbytes;

    repeat (3) tick();
    check("rst_valids", 64'({m00_axis_tvalid, m01_axis_tvalid,
                             runt_o, m01_axis_tlast}), 64'd0);
    check("rst_readies", 64'({s_len_tready, s_axis_tready}), 64'd0);
    check("rst_m00", 64'({m00_axis_tkeep, m00_axis_tdata}), 64'd0);
    check("rst_m01", 64'({m01_axis_tkeep, m01_axis_tdata}), 64'd0);
    rst = 1'b0;
    m00_axis_tready = 1'b1;
    m01_axis_tready = 1'b1;
    tick();
    check("len_rdy_after_rst", 64'(s_len_tready), 64'd1);
    check("in_rdy_idle", 64'(s_axis_tready), 64'd0);

    // L=2, three beats, last K=2
    exp_m00.push_back({4'b0011, 32'h0000AABB});
    exp_m01.push_back({1'b0, 4'b1111, 32'hCCDD1122});
    exp_m01.push_back({1'b1, 4'b1111, 32'h33445566});
    pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11,
           8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(2, pk);
    drain();

    // L=1, last K=3 needs a flush beat
    exp_m00.push_back({4'b0001, 32'h000000AA});
    exp_m01.push_back({1'b0, 4'b1111, 32'hBBCCDD11});
    exp_m01.push_back({1'b1, 4'b1100, 32'h22330000});
    pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33};
    send_pkt(1, pk);
    check("flush_stall", 64'(s_axis_tready), 64'd0);
    drain();

    // L=4 single-beat runt
    exp_m00.push_back({4'b0111, 32'h00DEADBE});
    runt_exp++;
    pk = '{8'hDE, 8'hAD, 8'hBE};
    send_pkt(4, pk);
    check("hdr_latency", 64'(m00_axis_tvalid), 64'd1);
    check("runt_pulse", 64'(runt_o), 64'd1);
    tick();
    check("runt_width", 64'(runt_o), 64'd0);
    drain();

    // L=4 passthrough
    exp_m00.push_back({4'b1111, 32'h01020304});
    exp_m01.push_back({1'b1, 4'b1111, 32'h05060708});
    pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt(4, pk);
    drain();

    // random lengths, sizes and ready throttling
    thr = 1'b1;
    for (int p = 0; p < 200; p++) begin
      lr = $urandom_range(0, 7);
      nbytes = $urandom_range(1, 5 * BW);
      pk = {};
      for (int i = 0; i < nbytes; i++) pk.push_back(8'($urandom));
      model(lr, pk);
      send_pkt(lr, pk);
    end
    drain();
    thr = 1'b0;
    m00_axis_tready = 1'b1;
    m01_axis_tready = 1'b1;
    check("runt_count", 64'(runt_seen), 64'(runt_exp));

    // reset during a BODY beat
    ignore = 1'b1;
    drive_len(2);
    drive_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    drive_beat(32'h11223344, 4'b1111, 1'b0);
    s_axis_tdata = 32'h55660000;
    s_axis_tkeep = 4'b1100;
    s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    rst = 1'b1;
    tick();
    check("mid_rst_valids", 64'({m00_axis_tvalid, m01_axis_tvalid,
                                 runt_o, s_axis_tready}), 64'd0);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    tick();
    check("mid_rst_after", 64'({s_len_tready, s_axis_tready,
                                m00_axis_tvalid, m01_axis_tvalid}), 64'h8);
    exp_m00.delete();
    exp_m01.delete();
    ignore = 1'b0;

    exp_m00.push_back({4'b0011, 32'h0000AABB});
    exp_m01.push_back({1'b0, 4'b1111, 32'hCCDD1122});
    exp_m01.push_back({1'b1, 4'b1111, 32'h33445566});
    pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11,
           8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(2, pk);
    drain();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

Strips a variable-length header from the front of each AXI-Stream packet. The header bytes go out on a dedicated header port, and the remaining payload is realigned so that it starts at byte 0 of its output port. This block is the receive-side counterpart of the header-insertion path and sits between the link-side stream and the payload consumer. The header length is supplied once per packet on a small length channel.

## Interface
Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (W).
- LEN_WD, $clog2(DATA_BYTE_WD+1), width of the header-length field.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_len_tvalid / s_len_tready  in / out  1 / 1  handshake for the header-length channel.
- s_len_tdata  in  LEN_WD  header length L in bytes, legal range 1..W; a value of 0 or greater than W is treated as W.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  handshake for the input stream.
- s_axis_tdata  in  DATA_WD  input data.
- s_axis_tkeep  in  DATA_BYTE_WD  input byte enables.
- s_axis_tlast  in  1  end of input packet.
- m00_axis_tvalid / m00_axis_tready  out / in  1 / 1  handshake for the header output.
- m00_axis_tdata  out  DATA_WD  header bytes, right-aligned.
- m00_axis_tkeep  out  DATA_BYTE_WD  low-contiguous byte enables for the header.
- m01_axis_tvalid / m01_axis_tready  out / in  1 / 1  handshake for the payload output.
- m01_axis_tdata / m01_axis_tkeep / m01_axis_tlast  out  DATA_WD / DATA_BYTE_WD / 1  realigned payload beat.
- runt_o  out  1  one-cycle pulse when a packet carries L bytes or fewer.

## Operation
Byte conventions:
- Byte 0 of a beat is tdata[DATA_WD-1 -: 8], enabled by tkeep[W-1].
- Input tkeep is all ones except on the tlast beat, which is high-contiguous (e.g. 4'b1100). K is the byte count of that last beat.

State machine (IDLE, HDR, BODY, FLUSH):
- IDLE:
  - s_len_tready=1.
  - On a length handshake, latch L and go to HDR.
- HDR:
  - Accept beat 0 only when the header register is empty.
  - Header output = the first L bytes of beat 0, right-aligned, with tkeep = low L bits set.
  - Store the remaining W-L bytes in the residue register.
  - Beat 0 without tlast: go to BODY.
  - Beat 0 with tlast and K ≤ L (runt):
    - Header keeps only K bytes.
    - runt_o pulses.
    - No payload beat is emitted.
    - Go to IDLE.
  - Beat 0 with tlast and K > L: emit one payload beat of K-L bytes with tlast, then go to IDLE.
- BODY: each accepted beat produces one payload beat = {residue W-L bytes, first L bytes of the current beat}. The remaining bytes become the new residue.
  - Last beat with K ≤ L: the output beat carries W-L+K bytes with tlast; go to IDLE.
  - Last beat with K > L: the output beat is full with no tlast; go to FLUSH. The input is stalled (s_axis_tready=0) while in FLUSH.
- FLUSH: emit one beat of K-L bytes, left-aligned, with tlast; go to IDLE.
- When L = W the residue is empty. Payload beats equal input beats 1..n unchanged, and the FLUSH state is never entered.

Output data hygiene: disabled byte lanes on both output ports are driven to zero.

## Timing
Reset values:
- All tvalid outputs are 0.
- s_len_tready=0, s_axis_tready=0.
- runt_o=0, m01_axis_tlast=0.
- m00/m01 tdata and tkeep are all 0.
- State is IDLE. The first cycle after rst falls has s_len_tready=1.

Latency:
- The header appears on m00 the cycle after the beat 0 handshake.
- Each payload beat appears on m01 the cycle after the input beat that completes it.
- Full throughput is one beat per cycle in BODY.

Handshake rules:
- Outputs are registered.
- tvalid holds, and tdata/tkeep/tlast stay stable, until the corresponding tready.
- Without the skid option, s_axis_tready = state-dependent enable AND (m01 register empty OR m01_axis_tready).

Simultaneous and mid-operation events:
- A length handshake for the next packet may coincide with the tlast payload handshake of the current one.
- The header and payload ports back-pressure independently. A stalled m00 blocks only the next beat 0.
- rst asserted mid-packet drops all in-flight data, including the header register, the residue and any FLUSH beat. The next packet must begin with a new length handshake.

## Configuration
Macro AXIS_EXTRACT_HDR_SKID_EN:
- Defined:
  - The payload output uses a 2-entry skid buffer.
  - s_axis_tready is a register output with no combinational path from m01_axis_tready.
  - Latency is unchanged while the skid buffer is empty.
- Undefined: a single output register with the combinational ready path described under Timing.
- Port behaviour is identical at the transaction level in both builds.

## Test plan
- L=2; input 0xAABBCCDD, 0x11223344, 0x55660000 (keep 1100, tlast) -> m00 0x0000AABB keep 0011. m01 0xCCDD1122 keep 1111, then 0x33445566 keep 1111 tlast.
- L=1; input 0xAABBCCDD, 0x11223300 (keep 1110, tlast) -> m00 0x000000AA keep 0001. m01 0xBBCCDD11 keep 1111, then FLUSH beat 0x22330000 keep 1100 tlast; s_axis_tready=0 during FLUSH.
- L=4; single beat 0xDEADBE00 (keep 1110, tlast) -> m00 0x00DEADBE keep 0111; runt_o pulses 1 cycle; no m01 beat.
- L=4; input 0x01020304, 0x05060708 (keep 1111, tlast) -> m00 0x01020304 keep 1111; m01 0x05060708 keep 1111 tlast.
- Random m00/m01 tready throttling (about 50%) over 200 packets with random L and K -> payload bytes equal input minus header, in order. Verify in both builds, with and without AXIS_EXTRACT_HDR_SKID_EN.
- Assert rst for one cycle during a BODY beat -> all valids are 0 the next cycle, s_len_tready=1, and the following packet is extracted correctly.
